// File: rtl/tt_switch_debounce_if.sv
// Switch conditioner bus: raw switch bits in, debounced level and edge pulses out.
interface tt_switch_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             any_change;

  modport master (output sw_raw, input sw_stable, sw_rise, sw_fall, any_change);
  modport slave  (input sw_raw, output sw_stable, sw_rise, sw_fall, any_change);
endinterface

// File: rtl/tt_switch_debounce.sv
// Per-bit synchroniser + debouncer for raw Tiny Tapeout switch inputs.
// Each bit is an independent lane; edge pulses are registered alongside the level.
module tt_switch_debounce_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser runs regardless of ena so the sampled view is never stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (ena) begin
        if (sync == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          // Change held long enough: commit and flag the direction.
          stable <= sync;
          cnt    <= '0;
          rise   <= sync;
          fall   <= ~sync;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

module tt_switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  tt_switch_debounce_if.slave  sw
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  tt_switch_debounce_lane #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lane [WIDTH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .raw   (sw.sw_raw),
    .stable(stable_w),
    .rise  (rise_w),
    .fall  (fall_w)
  );

  assign sw.sw_stable  = stable_w;
  assign sw.sw_rise    = rise_w;
  assign sw.sw_fall    = fall_w;
  assign sw.any_change = |(rise_w | fall_w);
endmodule

// File: tb/tb_tt_switch_debounce.sv
// Directed + randomized bench for tt_switch_debounce against a run-length reference model.
module tb_tt_switch_debounce;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  always #5 clk = ~clk;

  tt_switch_debounce_if #(.WIDTH(W)) sif ();

  tt_switch_debounce #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .sw   (sif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: raw samples delayed S edges, then a per-bit run length of
  // enabled samples that disagree with the accepted level.
  logic [W-1:0] m_hist [S];
  int           m_run  [W];
  logic [W-1:0] m_stable, m_rise, m_fall;

  function automatic void m_reset();
    for (int k = 0; k < S; k++) m_hist[k] = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
    m_stable = '0; m_rise = '0; m_fall = '0;
  endfunction

  function automatic void m_step(logic [W-1:0] raw, logic en);
    logic [W-1:0] seen;
    seen = m_hist[S-1];
    for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = raw;
    m_rise = '0; m_fall = '0;
    if (en) begin
      for (int b = 0; b < W; b++) begin
        if (seen[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_stable[b] = seen[b];
            m_run[b]    = 0;
            if (seen[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stable", 32'(sif.sw_stable), 32'(m_stable));
    chk("rise",   32'(sif.sw_rise),   32'(m_rise));
    chk("fall",   32'(sif.sw_fall),   32'(m_fall));
    chk("any",    32'(sif.any_change), 32'(|(m_rise | m_fall)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step(sif.sw_raw, ena);
    #1;
    check_all();
  endtask

  initial begin
    int nrise, nfall, nbad, cyc, len, gap;
    logic [W-1:0] base, rise_seen;

    // Reset state
    sif.sw_raw = '0;
    m_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: clean step on bit 0, accepted on the 6th edge
    sif.sw_raw = 8'h01;
    repeat (5) tick();
    chk("t1_early", 32'(sif.sw_stable), 32'h00);
    tick();
    chk("t1_stable", 32'(sif.sw_stable), 32'h01);
    chk("t1_rise", 32'(sif.sw_rise), 32'h01);
    chk("t1_any", 32'(sif.any_change), 32'h1);
    tick();
    chk("t1_rise_once", 32'(sif.sw_rise), 32'h00);

    // 2: bounce on bit 3
    nrise = 0;
    sif.sw_raw = 8'h09; repeat (3) tick();
    sif.sw_raw = 8'h01; tick();
    sif.sw_raw = 8'h09;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_no_early", 32'(sif.sw_stable[3]), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      nrise += int'(sif.sw_rise[3]);
    end
    chk("t2_stable", 32'(sif.sw_stable), 32'h09);
    chk("t2_one_rise", 32'(nrise), 32'd1);

    // 3: all bits fall together
    sif.sw_raw = 8'hFF; repeat (10) tick();
    chk("t3_ff", 32'(sif.sw_stable), 32'hFF);
    sif.sw_raw = 8'h00;
    nfall = 0; rise_seen = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rise_seen |= sif.sw_rise;
      if (sif.sw_fall != '0) begin
        nfall++;
        chk("t3_fall", 32'(sif.sw_fall), 32'hFF);
        chk("t3_any", 32'(sif.any_change), 32'h1);
      end
    end
    chk("t3_nfall", 32'(nfall), 32'd1);
    chk("t3_no_rise", 32'(rise_seen), 32'h00);
    chk("t3_stable", 32'(sif.sw_stable), 32'h00);

    // 4: ena dropped with cnt=2 on bit 1
    sif.sw_raw = 8'h02; repeat (4) tick();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_frozen", 32'(sif.sw_stable), 32'h00);
      chk("t4_nopulse", 32'({sif.sw_rise, sif.sw_fall}), 32'h0);
    end
    ena = 1'b1;
    tick();
    chk("t4_resume1", 32'(sif.sw_stable), 32'h00);
    tick();
    chk("t4_accept", 32'(sif.sw_stable), 32'h02);
    chk("t4_rise", 32'(sif.sw_rise), 32'h02);

    // 5: async reset mid-count, then a held bit 7 rises normally
    sif.sw_raw = 8'h80; repeat (3) tick();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all();
    chk("t5_rst_stable", 32'(sif.sw_stable), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t5_early", 32'(sif.sw_stable), 32'h00);
    tick();
    chk("t5_stable", 32'(sif.sw_stable), 32'h80);
    chk("t5_rise", 32'(sif.sw_rise), 32'h80);
    tick();

    // 6: short glitches must never be accepted
    base = 8'h80; cyc = 0; nbad = 0;
    while (cyc < 1000) begin
      len = $urandom_range(1, DC - 1);
      gap = $urandom_range(1, 3);
      sif.sw_raw = base ^ W'($urandom_range(1, 255));
      repeat (len) begin
        tick();
        if (sif.sw_stable != base || sif.sw_rise != '0 || sif.sw_fall != '0 || sif.any_change) nbad++;
      end
      sif.sw_raw = base;
      repeat (gap) begin
        tick();
        if (sif.sw_stable != base || sif.sw_rise != '0 || sif.sw_fall != '0 || sif.any_change) nbad++;
      end
      cyc += len + gap;
    end
    chk("t6_glitch_quiet", 32'(nbad), 32'd0);

    // Random holds with random ena, model-checked every cycle
    for (int i = 0; i < 150; i++) begin
      sif.sw_raw = W'($urandom);
      ena = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 8)) tick();
    end
    ena = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
